// File: rtl/leds_lab2_pkg.sv
// Shared widths and types for the lab 2 switch adder.
package leds_lab2_pkg;

    localparam int WIDTH = 4;

    typedef logic [WIDTH-1:0] operand_t;
    typedef logic [WIDTH:0]   sum_t;

endpackage : leds_lab2_pkg

// File: rtl/leds_lab2_full_adder.sv
// One-bit full adder cell used to build the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder

// File: rtl/leds_lab2.sv
// Adds two switch operands onto the LED bank combinationally and keeps a
// registered copy of the sum with a one-cycle change strobe.
module leds_lab2 #(
    parameter int WIDTH = leds_lab2_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] switch1,
    input  logic [WIDTH-1:0] switch2,
    output logic [WIDTH:0]   leds,
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH:0]   sum_q,
    output logic             sum_chg
);

    logic [WIDTH:0] carry_s;
    logic [WIDTH:0] sum_r;
    logic           chg_r;
    logic           differs_s;

    assign carry_s[0] = 1'b0;

    // Ripple chain: the final carry-out becomes the LED MSB, so nothing wraps.
    for (genvar i = 0; i < WIDTH; i++) begin : g_adder
        full_adder u_fa (
            .a    (switch1[i]),
            .b    (switch2[i]),
            .cin  (carry_s[i]),
            .s    (leds[i]),
            .cout (carry_s[i+1])
        );
    end

    assign leds[WIDTH] = carry_s[WIDTH];
    assign differs_s   = (leds != sum_r);

    // Capture the sum each cycle and flag when the captured value changes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sum_r <= '0;
            chg_r <= 1'b0;
        end else begin
            sum_r <= leds;
            chg_r <= differs_s;
        end
    end

    assign sum_q   = sum_r;
    assign sum_chg = chg_r;

endmodule : leds_lab2

// File: tb/tb_leds_lab2.sv
// Directed self-checking bench for leds_lab2: combinational sum, exhaustive
// sweep, registered copy, change strobe, reset and commutativity.
module tb_leds_lab2;
    import leds_lab2_pkg::*;

    operand_t switch1;
    operand_t switch2;
    sum_t     leds;
    logic     clk;
    logic     reset;
    sum_t     sum_q;
    logic     sum_chg;

    int   n_cmp;
    int   n_bad;
    int   comm_tests;
    int   comm_errs;
    sum_t exp_sum;
    sum_t fwd_sum;

    leds_lab2 dut (
        .switch1 (switch1),
        .switch2 (switch2),
        .leds    (leds),
        .clk     (clk),
        .reset   (reset),
        .sum_q   (sum_q),
        .sum_chg (sum_chg)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input sum_t obs, input sum_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Directed stimulus sequence.
    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        comm_tests = 0;
        comm_errs  = 0;
        reset      = 1'b0;
        switch1    = 4'b0000;
        switch2    = 4'b0000;

        // Combinational sum while reset is low.
        #1 check("zero_sum", leds, 5'b00000);
        switch1 = 4'b1111; switch2 = 4'b0001;
        #1 check("carry_f_plus_1", leds, 5'b10000);
        switch1 = 4'b1111; switch2 = 4'b1111;
        #1 check("max_f_plus_f", leds, 5'b11110);

        // Registers held clear by reset.
        @(negedge clk);
        check("reset_sum_q", sum_q, 5'b00000);
        check("reset_sum_chg", {4'b0000, sum_chg}, 5'b00000);
        check("leds_in_reset", leds, 5'b11110);

        #12;
        reset = 1'b1;

        // Exhaustive sweep: apply on posedge, check on negedge.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                @(posedge clk);
                switch1 = operand_t'(a);
                switch2 = operand_t'(b);
                exp_sum = sum_t'(a + b);
                @(negedge clk);
                check("exhaustive", leds, exp_sum);
            end
        end

        // Registered path: previous sum_q is 30, new sum is 7.
        switch1 = 4'b0011; switch2 = 4'b0100;
        @(negedge clk);
        check("reg_sum_q", sum_q, 5'b00111);
        check("reg_chg_pulse", {4'b0000, sum_chg}, 5'b00001);
        @(negedge clk);
        check("reg_sum_hold", sum_q, 5'b00111);
        check("reg_chg_low", {4'b0000, sum_chg}, 5'b00000);

        // Mid-operation reset.
        reset = 1'b0;
        #1 check("leds_reset_asserted", leds, 5'b00111);
        @(negedge clk);
        check("midrst_sum_q", sum_q, 5'b00000);
        check("midrst_chg", {4'b0000, sum_chg}, 5'b00000);
        check("midrst_leds", leds, 5'b00111);

        // First edge after release with a non-zero sum.
        reset = 1'b1;
        @(negedge clk);
        check("release_sum_q", sum_q, 5'b00111);
        check("release_chg", {4'b0000, sum_chg}, 5'b00001);

        // First edge after release with a zero sum: no strobe.
        reset = 1'b0;
        switch1 = 4'b0000; switch2 = 4'b0000;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("release_zero_sum_q", sum_q, 5'b00000);
        check("release_zero_chg", {4'b0000, sum_chg}, 5'b00000);

        // Commutativity sweep.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                switch1 = operand_t'(a);
                switch2 = operand_t'(b);
                #1 fwd_sum = leds;
                switch1 = operand_t'(b);
                switch2 = operand_t'(a);
                #1;
                comm_tests++;
                if (leds !== fwd_sum || fwd_sum !== sum_t'(a + b)) comm_errs++;
                check("commute", leds, fwd_sum);
            end
        end
        $display("%0d tests completed with %0d errors", comm_tests, comm_errs);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_leds_lab2
